// File: rtl/uart_tx_word_queue.sv
// Word FIFO feeding the multi-byte UART transmitter: one word per send pulse, next word after tx_done.
// Define UART_TXQ_WDT_EN to add a WAIT-state watchdog (parameter WDT_CYCLES, output wdt_err).
module uart_tx_word_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 0
`ifdef UART_TXQ_WDT_EN
    ,
    parameter int WDT_CYCLES = 1 << 20
`endif
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W:0]       level,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_send_en,
    input  logic                  tx_done,
    output logic                  busy
`ifdef UART_TXQ_WDT_EN
    ,
    output logic                  wdt_err
`endif
);
    localparam int DEPTH = 1 << ADDR_W;

    // Handshake: a word is accepted on any edge with wr_en && !full; a word is
    // issued with a one-cycle tx_send_en and is in flight until tx_done is seen in WAIT.
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count;
    logic [15:0]           gap_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push;
    logic                  pop;
`ifdef UART_TXQ_WDT_EN
    localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);
    logic [31:0]           wdt_cnt;
    logic                  wdt_fire;
`endif

    assign full  = (count == (ADDR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign busy  = (state != IDLE) || !empty;
    assign push  = wr_en && !full;
    assign pop   = (state == LOAD);

`ifdef UART_TXQ_WDT_EN
    assign wdt_fire = (state == WAIT) && !tx_done && (wdt_cnt == WDT_LAST);
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            tx_data    <= '0;
            tx_send_en <= 1'b0;
            gap_cnt    <= '0;
`ifdef UART_TXQ_WDT_EN
            wdt_cnt    <= '0;
            wdt_err    <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (ADDR_W + 1)'(1);
            end else if (!push && pop) begin
                count <= count - (ADDR_W + 1)'(1);
            end

            // A dropped write outranks a clear in the same cycle.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

`ifdef UART_TXQ_WDT_EN
            wdt_err <= wdt_fire;
            if ((state == WAIT) && !tx_done && !wdt_fire) begin
                wdt_cnt <= wdt_cnt + 32'd1;
            end else begin
                wdt_cnt <= '0;
            end
`endif

            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data    <= mem[rd_ptr];
                    tx_send_en <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    tx_send_en <= 1'b0;
                    if (tx_done) begin
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= 16'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end
                    end
`ifdef UART_TXQ_WDT_EN
                    else if (wdt_fire) begin
                        state <= IDLE;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == 16'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_word_queue.sv
// Directed bench for uart_tx_word_queue: a GAP_CYCLES=0 instance and a GAP_CYCLES=5 instance.
`timescale 1ns/1ps
module tb_uart_tx_word_queue;
    localparam int DW = 16;
    localparam int AW = 4;
`ifdef UART_TXQ_WDT_EN
    localparam int RESP_DLY = 40;
`else
    localparam int RESP_DLY = 100;
`endif

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          tx_done = 1'b0;
    logic          full, empty, overflow, tx_send_en, busy;
    logic [AW:0]   level;
    logic [DW-1:0] tx_data;

    logic [DW-1:0] g_wr_data = '0;
    logic          g_wr_en = 1'b0;
    logic          g_ovf_clr = 1'b0;
    logic          g_tx_done = 1'b0;
    logic          g_full, g_empty, g_overflow, g_tx_send_en, g_busy;
    logic [AW:0]   g_level;
    logic [DW-1:0] g_tx_data;
`ifdef UART_TXQ_WDT_EN
    logic          wdt_err, g_wdt_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    always #5 Clk = ~Clk;

    uart_tx_word_queue #(.DATA_WIDTH(DW), .ADDR_W(AW), .GAP_CYCLES(0)
`ifdef UART_TXQ_WDT_EN
        , .WDT_CYCLES(50)
`endif
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .wr_data(wr_data), .wr_en(wr_en), .ovf_clr(ovf_clr),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_data(tx_data), .tx_send_en(tx_send_en), .tx_done(tx_done), .busy(busy)
`ifdef UART_TXQ_WDT_EN
        , .wdt_err(wdt_err)
`endif
    );

    uart_tx_word_queue #(.DATA_WIDTH(DW), .ADDR_W(AW), .GAP_CYCLES(5)
`ifdef UART_TXQ_WDT_EN
        , .WDT_CYCLES(50)
`endif
    ) dut_gap (
        .Clk(Clk), .Rst_n(Rst_n), .wr_data(g_wr_data), .wr_en(g_wr_en), .ovf_clr(g_ovf_clr),
        .full(g_full), .empty(g_empty), .level(g_level), .overflow(g_overflow),
        .tx_data(g_tx_data), .tx_send_en(g_tx_send_en), .tx_done(g_tx_done), .busy(g_busy)
`ifdef UART_TXQ_WDT_EN
        , .wdt_err(g_wdt_err)
`endif
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Edges until the selected send pulse is seen; -1 if the limit expires.
    task automatic wait_pulse(input bit use_gap, input int limit, output int edges);
        int i;
        i = 0;
        edges = -1;
        while (edges < 0 && i < limit) begin
            i++;
            tick();
            if ((use_gap ? g_tx_send_en : tx_send_en) === 1'b1) edges = i;
        end
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++;
        if ({full, empty, level, overflow, busy, tx_send_en} !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_flags: got %b want %b", {full, empty, level, overflow, busy, tx_send_en}, 10'b0100000000);
        end
        n_cmp++;
        if (tx_data !== 16'h0000 || g_tx_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_tx_data: got %h/%h want 0000", tx_data, g_tx_data);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        int extra;
        wr_data = 16'hA55A;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if ({tx_send_en, level, busy} !== {1'b0, 5'd1, 1'b1}) begin
            n_err++;
            $display("FAIL single_after_write: got send=%b level=%0d busy=%b want 0/1/1", tx_send_en, level, busy);
        end
        tick();
        n_cmp++;
        if (tx_send_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_early_send: got %b want 0", tx_send_en);
        end
        tick();
        n_cmp++;
        if ({tx_send_en, tx_data, level} !== {1'b1, 16'hA55A, 5'd0}) begin
            n_err++;
            $display("FAIL single_send: got send=%b data=%h level=%0d want 1/a55a/0", tx_send_en, tx_data, level);
        end
        tick();
        n_cmp++;
        if ({tx_send_en, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL single_pulse_width: got send=%b busy=%b want 0/1", tx_send_en, busy);
        end
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        extra = 0;
        repeat (5) begin
            tick();
            if (tx_send_en === 1'b1) extra++;
        end
        n_cmp++;
        if ({empty, busy} !== 2'b10 || extra !== 0) begin
            n_err++;
            $display("FAIL single_idle: got empty=%b busy=%b extra=%0d want 1/0/0", empty, busy, extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] words [3];
        int lv [3];
        int edges, extra;
        words = '{16'h1111, 16'h2222, 16'h3333};
        lv = '{2, 1, 0};
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = words[i];
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                wait_pulse(1'b0, 10, edges);
                n_cmp++;
                if (edges !== 2) begin
                    n_err++;
                    $display("FAIL b2b_latency[%0d]: got %0d edges want 2", i, edges);
                end
            end
            n_cmp++;
            if ({tx_send_en, tx_data} !== {1'b1, words[i]}) begin
                n_err++;
                $display("FAIL b2b_data[%0d]: got send=%b data=%h want 1/%h", i, tx_send_en, tx_data, words[i]);
            end
            n_cmp++;
            if (level !== 5'(lv[i])) begin
                n_err++;
                $display("FAIL b2b_level[%0d]: got %0d want %0d", i, level, lv[i]);
            end
            extra = 0;
            for (int k = 1; k < RESP_DLY; k++) begin
                tick();
                if (tx_send_en === 1'b1) extra++;
            end
            n_cmp++;
            if (extra !== 0) begin
                n_err++;
                $display("FAIL b2b_extra_pulse[%0d]: got %0d want 0", i, extra);
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        extra = 0;
        repeat (10) begin
            tick();
            if (tx_send_en === 1'b1) extra++;
        end
        n_cmp++;
        if ({extra == 0, empty, busy} !== 3'b110) begin
            n_err++;
            $display("FAIL b2b_idle: got extra=%0d empty=%b busy=%b want 0/1/0", extra, empty, busy);
        end
    endtask

    task automatic test_overflow;
        logic [DW-1:0] exp;
        int edges, extra;
        exp_q.delete();
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 16'h0100 + 16'(i);
            exp_q.push_back(wr_data);
            tick();
        end
        n_cmp++;
        if ({full, overflow, level} !== {1'b1, 1'b0, 5'd16}) begin
            n_err++;
            $display("FAIL ovf_fill: got full=%b ovf=%b level=%0d want 1/0/16", full, overflow, level);
        end
        wr_data = 16'hBAD0;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if ({overflow, level} !== {1'b1, 5'd16}) begin
            n_err++;
            $display("FAIL ovf_drop: got ovf=%b level=%0d want 1/16", overflow, level);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        ovf_clr = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'hBAD1;
        tick();
        ovf_clr = 1'b0;
        wr_en = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drop_beats_clear: got %b want 1", overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp = exp_q.pop_front();
        n_cmp++;
        if (tx_data !== exp) begin
            n_err++;
            $display("FAIL ovf_inflight: got %h want %h", tx_data, exp);
        end
        // Write while full lands on the same edge as the LOAD pop.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        wr_en = 1'b1;
        wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        exp = exp_q.pop_front();
        n_cmp++;
        if ({overflow, level, tx_send_en, tx_data} !== {1'b1, 5'd15, 1'b1, exp}) begin
            n_err++;
            $display("FAIL ovf_full_pop: got ovf=%b level=%0d send=%b data=%h want 1/15/1/%h", overflow, level, tx_send_en, tx_data, exp);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            repeat (2) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            wait_pulse(1'b0, 10, edges);
            n_cmp++;
            if (edges !== 2 || tx_data !== exp) begin
                n_err++;
                $display("FAIL ovf_drain: got edges=%0d data=%h want 2/%h", edges, tx_data, exp);
            end
        end
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        extra = 0;
        repeat (10) begin
            tick();
            if (tx_send_en === 1'b1) extra++;
        end
        n_cmp++;
        if ({extra == 0, empty, busy, overflow} !== 4'b1100) begin
            n_err++;
            $display("FAIL ovf_drain_end: got extra=%0d empty=%b busy=%b ovf=%b want 0/1/0/0", extra, empty, busy, overflow);
        end
    endtask

    task automatic test_gap;
        int edges, extra;
        g_wr_en = 1'b1;
        g_wr_data = 16'hAAAA;
        tick();
        g_wr_data = 16'hBBBB;
        tick();
        g_wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({g_tx_send_en, g_tx_data} !== {1'b1, 16'hAAAA}) begin
            n_err++;
            $display("FAIL gap_first: got send=%b data=%h want 1/aaaa", g_tx_send_en, g_tx_data);
        end
        repeat (3) tick();
        g_tx_done = 1'b1;
        tick();
        g_tx_done = 1'b0;
        extra = 0;
        tick();
        if (g_tx_send_en === 1'b1) extra++;
        tick();
        if (g_tx_send_en === 1'b1) extra++;
        // Stray completion while in GAP must not shorten or restart the gap.
        g_tx_done = 1'b1;
        tick();
        g_tx_done = 1'b0;
        if (g_tx_send_en === 1'b1) extra++;
        wait_pulse(1'b1, 12, edges);
        n_cmp++;
        if (extra !== 0 || edges + 3 !== 7) begin
            n_err++;
            $display("FAIL gap_latency: got extra=%0d edges=%0d want 0/7", extra, edges + 3);
        end
        n_cmp++;
        if (g_tx_data !== 16'hBBBB) begin
            n_err++;
            $display("FAIL gap_second_data: got %h want bbbb", g_tx_data);
        end
        repeat (2) tick();
        g_tx_done = 1'b1;
        tick();
        g_tx_done = 1'b0;
        n_cmp++;
        if (g_busy !== 1'b1) begin
            n_err++;
            $display("FAIL gap_busy_in_gap: got %b want 1", g_busy);
        end
        repeat (10) tick();
        n_cmp++;
        if ({g_empty, g_busy} !== 2'b10) begin
            n_err++;
            $display("FAIL gap_idle: got empty=%b busy=%b want 1/0", g_empty, g_busy);
        end
    endtask

    task automatic test_reset_midop;
        int edges, extra;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 16'h5000 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({level, busy, tx_send_en} !== {5'd4, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midop_pre: got level=%0d busy=%b send=%b want 4/1/0", level, busy, tx_send_en);
        end
        #2 Rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({full, empty, level, overflow, busy, tx_send_en, tx_data} !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL midop_async_reset: got empty=%b level=%0d busy=%b data=%h want 1/0/0/0000", empty, level, busy, tx_data);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            tick();
            if (tx_send_en === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL midop_no_send: got extra=%0d empty=%b want 0/1", extra, empty);
        end
        wr_data = 16'h7E57;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        wait_pulse(1'b0, 10, edges);
        n_cmp++;
        if (edges !== 2 || tx_data !== 16'h7E57) begin
            n_err++;
            $display("FAIL midop_restart: got edges=%0d data=%h want 2/7e57", edges, tx_data);
        end
        // Reset landing inside the send pulse must drop it at once.
        #1 Rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx_send_en !== 1'b0) begin
            n_err++;
            $display("FAIL midop_send_drop: got %b want 0", tx_send_en);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        extra = 0;
        repeat (10) begin
            tick();
            if (tx_send_en === 1'b1) extra++;
        end
        n_cmp++;
        if ({extra == 0, empty, busy} !== 3'b110) begin
            n_err++;
            $display("FAIL midop_final_idle: got extra=%0d empty=%b busy=%b want 0/1/0", extra, empty, busy);
        end
    endtask

`ifdef UART_TXQ_WDT_EN
    task automatic test_wdt;
        int wdt_edge, wdt_hi, send_edge;
        logic [DW-1:0] send_data;
        wr_en = 1'b1;
        wr_data = 16'h0D01;
        tick();
        wr_data = 16'h0D02;
        tick();
        wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({tx_send_en, tx_data, wdt_err} !== {1'b1, 16'h0D01, 1'b0}) begin
            n_err++;
            $display("FAIL wdt_first: got send=%b data=%h wdt=%b want 1/0d01/0", tx_send_en, tx_data, wdt_err);
        end
        wdt_edge = -1;
        wdt_hi = 0;
        send_edge = -1;
        send_data = '0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (wdt_err === 1'b1) begin
                wdt_hi++;
                if (wdt_edge < 0) wdt_edge = i;
            end
            if (tx_send_en === 1'b1 && send_edge < 0) begin
                send_edge = i;
                send_data = tx_data;
            end
        end
        n_cmp++;
        if (wdt_edge !== 50 || wdt_hi !== 1) begin
            n_err++;
            $display("FAIL wdt_pulse: got edge=%0d width=%0d want 50/1", wdt_edge, wdt_hi);
        end
        n_cmp++;
        if (send_edge !== 52 || send_data !== 16'h0D02) begin
            n_err++;
            $display("FAIL wdt_next_word: got edge=%0d data=%h want 52/0d02", send_edge, send_data);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({empty, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL wdt_idle: got empty=%b busy=%b want 1/0", empty, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_gap();
        test_reset_midop();
`ifdef UART_TXQ_WDT_EN
        test_wdt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded 300000 ns");
        $fatal(1, "timeout");
    end
endmodule
